ex_div_unit: RTL



---
 rtl/ex_div_unit_pkg.sv | 24 ++
 rtl/ex_div_unit_if.sv | 26 ++
 rtl/ex_div_unit_div_step.sv | 22 ++
 rtl/ex_div_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ex_div_unit_pkg.sv
// Shared encodings and defaults for the EX-stage iterative divider.
// Imported by the interface, the step datapath and the top.
package ex_div_unit_pkg;

  localparam int DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // The counter must be able to hold DATA_W itself, hence the extra bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/ex_div_unit_if.sv
// EX-stage <-> divider request/result bundle.
// The EX stage is the master; the divider is the slave.
interface ex_div_unit_if
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
);
  logic                  start_i;
  logic                  signed_i;
  logic [DATA_W-1:0]     dividend_i;
  logic [DATA_W-1:0]     divisor_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output start_i, signed_i, dividend_i, divisor_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_i, dividend_i, divisor_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/ex_div_unit_div_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it does not go negative.
module ex_div_unit_div_step
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic              q_bit_o
);

  logic [DATA_W:0] trial;

  assign trial   = {rem_i, bit_i} - {1'b0, divisor_i};
  assign q_bit_o = ~trial[DATA_W];
  // On restore the shifted remainder is below the divisor, so it fits DATA_W bits.
  assign rem_o   = q_bit_o ? trial[DATA_W-1:0] : {rem_i[DATA_W-2:0], bit_i};

endmodule

// File: rtl/ex_div_unit.sv
// Iterative restoring divider for DIV/DIVU; returns {remainder, quotient}
// for HI/LO and holds the EX stage stalled until the result is ready.
module ex_div_unit
  import ex_div_unit_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  ex_div_unit_if.slave bus
);

  localparam int              CNT_W    = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  div_state_e            state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [DATA_W-1:0]     rem_reg, rem_next;
  logic [DATA_W-1:0]     quo_reg, quo_next;
  logic [DATA_W-1:0]     dvs_reg, dvs_next;
  logic                  a_neg_reg, a_neg_next;
  logic                  b_neg_reg, b_neg_next;
  logic                  sgn_reg, sgn_next;
  logic [2*DATA_W-1:0]   result_reg, result_next;
  logic                  ready_reg, ready_next;

  logic [DATA_W-1:0]     step_rem;
  logic                  step_q;
  logic [DATA_W-1:0]     dividend_mag, divisor_mag;
  logic                  q_neg, r_neg;
  logic [DATA_W-1:0]     quo_fix, rem_fix;

  ex_div_unit_div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i     (rem_reg),
    .bit_i     (quo_reg[DATA_W-1]),
    .divisor_i (dvs_reg),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  assign dividend_mag = (bus.signed_i && bus.dividend_i[DATA_W-1]) ?
                        (~bus.dividend_i + DATA_W'(1)) : bus.dividend_i;
  assign divisor_mag  = (bus.signed_i && bus.divisor_i[DATA_W-1]) ?
                        (~bus.divisor_i + DATA_W'(1)) : bus.divisor_i;

  // Negation is modular, so 0x80000000 / -1 wraps back to 0x80000000.
  assign q_neg   = sgn_reg & (a_neg_reg ^ b_neg_reg);
  assign r_neg   = sgn_reg & a_neg_reg;
  assign quo_fix = q_neg ? (~quo_reg + DATA_W'(1)) : quo_reg;
  assign rem_fix = r_neg ? (~rem_reg + DATA_W'(1)) : rem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= DivFree;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      dvs_reg    <= '0;
      a_neg_reg  <= 1'b0;
      b_neg_reg  <= 1'b0;
      sgn_reg    <= 1'b0;
      result_reg <= '0;
      ready_reg  <= DivResultNotReady;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      dvs_reg    <= dvs_next;
      a_neg_reg  <= a_neg_next;
      b_neg_reg  <= b_neg_next;
      sgn_reg    <= sgn_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    dvs_next    = dvs_reg;
    a_neg_next  = a_neg_reg;
    b_neg_next  = b_neg_reg;
    sgn_next    = sgn_reg;
    result_next = result_reg;
    ready_next  = DivResultNotReady;

    if (bus.annul_i) begin
      state_next = DivFree;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        DivFree: begin
          if (bus.start_i == DivStart) begin
            if (bus.divisor_i == '0) begin
              state_next = DivByZero;
            end else begin
              state_next = DivOn;
              cnt_next   = '0;
              rem_next   = '0;
              quo_next   = dividend_mag;
              dvs_next   = divisor_mag;
              a_neg_next = bus.dividend_i[DATA_W-1];
              b_neg_next = bus.divisor_i[DATA_W-1];
              sgn_next   = bus.signed_i;
            end
          end
        end
        DivByZero: begin
          state_next  = DivEnd;
          result_next = '0;
          ready_next  = DivResultReady;
        end
        DivOn: begin
          if (cnt_reg != CNT_LAST) begin
            rem_next = step_rem;
            quo_next = {quo_reg[DATA_W-2:0], step_q};
            cnt_next = cnt_reg + CNT_W'(1);
          end else begin
            result_next = {rem_fix, quo_fix};
            ready_next  = DivResultReady;
            state_next  = DivEnd;
          end
        end
        DivEnd: begin
          state_next = DivFree;
        end
        default: begin
          state_next = DivFree;
        end
      endcase
    end
  end

  assign bus.result_o   = result_reg;
  assign bus.ready_o    = ready_reg;
  assign bus.stallreq_o = bus.start_i & ~ready_reg & ~bus.annul_i;

endmodule
